sync_debounce_edge: RTL and testbench
=====================================

Name: sync_debounce_edge

Overview:
- Downstream consumer of the input synchroniser; takes its already-synchronised output `input_sync` as its only data input.
- Filters bounce and glitches: a new level is accepted only after it has held for DEBOUNCE_CYCLES consecutive clock samples.
- Outputs the debounced level, one-cycle rise/fall pulses, and a count of accepted rising edges (press count) for lab display logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive samples of a new level required before acceptance; legal range >= 2.
- CNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- input_sync  input  1  synchronised input from the upstream synchroniser; no further metastability handling here.
- level_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle high when level_out goes 0->1.
- fall_pulse  output  1  one-cycle high when level_out goes 1->0.
- press_count  output  CNT_W  number of accepted rising edges.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=STABLE_LO, stable counter=0.
  - level_out=0, rise_pulse=0, fall_pulse=0, press_count=0.
  - Reset has priority over every other event, including a pending acceptance in the same cycle; the pulse is lost.
- State register, 4 states:
  - STABLE_LO: if input_sync=1, go to WAIT_HI with cnt=1; else stay, cnt=0.
  - WAIT_HI:
    - input_sync=0: return to STABLE_LO, cnt=0 (glitch rejected, no outputs change).
    - input_sync=1 and cnt<DEBOUNCE_CYCLES-1: cnt++.
    - input_sync=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, cnt=0, level_out<=1, rise_pulse<=1, press_count<=press_count+1.
  - STABLE_HI and WAIT_LO: mirror of the above with polarities swapped. Acceptance sets level_out<=0 and fall_pulse<=1; press_count is unchanged.
- Latency:
  - Let edge E0 be the first edge sampling the new value.
  - level_out and the pulse become visible after edge E0+DEBOUNCE_CYCLES-1, i.e. on the DEBOUNCE_CYCLES-th consecutive sample.
  - Any reverting sample before that restarts qualification from zero.
- Pulses:
  - Registered, exactly one cycle wide.
  - rise_pulse and fall_pulse are never high together.
  - Minimum spacing between any two pulses is DEBOUNCE_CYCLES cycles.
- Stable counter width: $clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES-1.
- press_count wraps from 2^CNT_W-1 to 0 (default build).
- All outputs are registered; no combinational path from input_sync to any output.

Optional Feature:
- Macro: PRESS_COUNT_SAT_EN.
- Defined: press_count saturates at 2^CNT_W-1. Further accepted rises still produce rise_pulse, but the count holds at the maximum.
- Undefined: press_count wraps modulo 2^CNT_W.

Decomposition:
- Shared include file sync_debounce_defs.vh contains:
  - the 2-bit state encodings: STABLE_LO=2'b00, WAIT_HI=2'b01, STABLE_HI=2'b11, WAIT_LO=2'b10;
  - the default DEBOUNCE_CYCLES value.
- Sub-module press_counter: CNT_W-bit enable counter with synchronous active-low reset. The PRESS_COUNT_SAT_EN wrap/saturate choice lives inside it.
- FSM, stable counter and pulse registers stay in the top module.

Test Plan:
- Reset:
  - Stimulus: clk period 60 ns, DEBOUNCE_CYCLES=4, rst_n=0 for 3 cycles while input_sync=1.
  - Required: all outputs 0 during reset.
  - After release: level_out=1 and rise_pulse high for one cycle on the 4th consecutive sample; press_count=1.
- Fast toggling:
  - Stimulus: input_sync toggling every 160 ns (about 2.7 cycles per level).
  - Required: level_out stays 0, no pulses, press_count stays 0 for 2000 ns.
- Clean press/release:
  - Stimulus: input_sync high for 10 cycles, then low for 10 cycles.
  - Required: rise_pulse on the 4th high sample, fall_pulse on the 4th low sample, each exactly 1 cycle; press_count=1.
- Glitch mid-qualification:
  - Stimulus: input_sync high 3 cycles, low 1 cycle, then high 4 cycles.
  - Required: one rise_pulse, only after the final 4-sample run; press_count increments by 1.
- Wrap and saturate:
  - Stimulus: CNT_W=2, five clean presses.
  - Default build: press_count reads 1, 2, 3, 0, 1.
  - With PRESS_COUNT_SAT_EN: press_count reads 1, 2, 3, 3, 3, with 5 rise_pulses either way.
- Reset during acceptance:
  - Stimulus: assert rst_n=0 on the same edge as the 4th qualifying sample.
  - Required: no pulse; level_out=0; press_count=0; state returns to STABLE_LO.

Source files
------------

// File: rtl/sync_debounce_edge_pkg.sv
// sync_debounce_edge_pkg
// Shared constants for the debouncer slice:
//   - 2-bit FSM state encodings (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO)
//   - default qualification length used when DEBOUNCE_CYCLES is not overridden
// The encodings are chosen so that bit 1 of a stable state equals its level.
package sync_debounce_edge_pkg;

   localparam logic [1:0] STABLE_LO = 2'b00;
   localparam logic [1:0] WAIT_HI   = 2'b01;
   localparam logic [1:0] STABLE_HI = 2'b11;
   localparam logic [1:0] WAIT_LO   = 2'b10;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync_debounce_edge_press_counter.sv
// press_counter
// CNT_W-bit enable counter with synchronous active-low reset. Counts accepted
// rising edges for the debouncer.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset, clears the count
//   en_i     - one-cycle increment request
//   count_o  - current count
//
// Build option: PRESS_COUNT_SAT_EN
//   defined   -> count saturates at 2^CNT_W-1
//   undefined -> count wraps modulo 2^CNT_W
module press_counter
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: hold unless enabled; at the maximum either hold or wrap
   // depending on the build option.
   always_comb begin
      count_d = count_q;
      if (en_i) begin
`ifdef PRESS_COUNT_SAT_EN
         if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
         end
`else
         count_d = count_q + CNT_W'(1);
`endif
      end
   end

   // Count register; reset wins over any increment in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge
// Debounces an already-synchronised input: a new level is accepted only after
// DEBOUNCE_CYCLES consecutive samples of it. Produces the debounced level,
// registered one-cycle rise/fall pulses and a count of accepted rising edges.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - synchronous active-low reset
//   input_sync   - synchronised raw input
//   level_out    - debounced level
//   rise_pulse   - one cycle high when level_out goes 0->1
//   fall_pulse   - one cycle high when level_out goes 1->0
//   press_count  - accepted rising edges (CNT_W bits)
//
// Build option: PRESS_COUNT_SAT_EN (handled inside press_counter) makes
// press_count saturate instead of wrapping.
module sync_debounce_edge
   import sync_debounce_edge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             input_sync,
   output logic             level_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] press_count
);

   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          inc;

   // Qualification FSM. The counter holds how many consecutive samples of the
   // candidate level have been seen; the sample that would make it reach
   // DEBOUNCE_CYCLES is the accepting one, so it never exceeds CNT_LAST.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      inc     = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (input_sync) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_HI: begin
            if (!input_sync) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
               inc     = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!input_sync) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_LO: begin
            if (input_sync) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and output registers. Reset takes priority, so an
   // acceptance landing on a reset edge is discarded along with its pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   press_counter #(
      .CNT_W (CNT_W)
   ) u_press_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (inc),
      .count_o (press_count)
   );

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge
// Self-checking bench for sync_debounce_edge (DEBOUNCE_CYCLES=4, CNT_W=2).
// A reference model keeps the recent input history and accepts a new level
// once the last DEBOUNCE_CYCLES samples all differ from the current level.
// Honours PRESS_COUNT_SAT_EN when defined at compile time.
module tb_sync_debounce_edge;

   localparam int D     = 4;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          input_sync;
   logic          level_out;
   logic          rise_pulse;
   logic          fall_pulse;
   logic [CW-1:0] press_count;

   int compared   = 0;
   int mismatched = 0;
   int riseSeen   = 0;
   bit checkEn    = 0;

   // Reference model state
   bit mLevel = 0;
   bit mRise  = 0;
   bit mFall  = 0;
   int mCount = 0;
   bit hist[$];

   sync_debounce_edge #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_sync  (input_sync),
      .level_out   (level_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .press_count (press_count)
   );

   // 60 ns clock period
   initial clk = 1'b0;
   always #30 clk = ~clk;

   // Model update on each rising edge from the sampled inputs.
   always @(posedge clk) begin
      bit allNew;
      if (!rst_n) begin
         hist.delete();
         mLevel = 0;
         mRise  = 0;
         mFall  = 0;
         mCount = 0;
      end else begin
         mRise = 0;
         mFall = 0;
         hist.push_back(input_sync);
         if (hist.size() > D) void'(hist.pop_front());
         allNew = (hist.size() == D);
         foreach (hist[i]) if (hist[i] == mLevel) allNew = 0;
         if (allNew) begin
            mLevel = !mLevel;
            if (mLevel) begin
               mRise = 1;
`ifdef PRESS_COUNT_SAT_EN
               if (mCount < CMAX) mCount = mCount + 1;
`else
               mCount = (mCount + 1) % (CMAX + 1);
`endif
            end else begin
               mFall = 1;
            end
            hist.delete();
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model, away from the edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("level_out",   int'(level_out),   int'(mLevel));
         checkOutput("rise_pulse",  int'(rise_pulse),  int'(mRise));
         checkOutput("fall_pulse",  int'(fall_pulse),  int'(mFall));
         checkOutput("press_count", int'(press_count), mCount);
         if (rise_pulse && fall_pulse) checkOutput("pulse_overlap", 1, 0);
      end
      if (rise_pulse === 1'b1) riseSeen++;
   end

   // One sample: drive at the falling edge, return 1 ns after the sampling edge.
   task automatic applyStimulus(input logic v);
      @(negedge clk);
      rst_n      = 1'b1;
      input_sync = v;
      @(posedge clk);
      #1;
   endtask

   task automatic applyRun(input logic v, input int n);
      for (int i = 0; i < n; i++) applyStimulus(v);
   endtask

   task automatic resetCycle(input logic v);
      @(negedge clk);
      rst_n      = 1'b0;
      input_sync = v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkLiteral(input string name, input logic lvl, input logic r,
                               input logic f, input int cnt);
      checkOutput({name, ".level"}, int'(level_out),   int'(lvl));
      checkOutput({name, ".rise"},  int'(rise_pulse),  int'(r));
      checkOutput({name, ".fall"},  int'(fall_pulse),  int'(f));
      checkOutput({name, ".count"}, int'(press_count), cnt);
   endtask

   initial begin
      int base;
      int expSeq[5];
      rst_n      = 1'b0;
      input_sync = 1'b1;

      // Reset held 3 cycles with input high
      for (int i = 0; i < 3; i++) begin
         resetCycle(1'b1);
         checkEn = 1;
         checkLiteral("reset", 0, 0, 0, 0);
      end
      applyRun(1'b1, 3);
      checkLiteral("post_reset_s3", 0, 0, 0, 0);
      applyStimulus(1'b1);
      checkLiteral("post_reset_s4", 1, 1, 0, 1);
      applyStimulus(1'b1);
      checkLiteral("post_reset_s5", 1, 0, 0, 1);

      // Clean press / release from a fresh reset
      resetCycle(1'b0);
      applyRun(1'b1, 3);
      checkLiteral("press_s3", 0, 0, 0, 0);
      applyStimulus(1'b1);
      checkLiteral("press_s4", 1, 1, 0, 1);
      applyRun(1'b1, 6);
      applyRun(1'b0, 3);
      checkLiteral("release_s3", 1, 0, 0, 1);
      applyStimulus(1'b0);
      checkLiteral("release_s4", 0, 0, 1, 1);
      applyStimulus(1'b0);
      checkLiteral("release_s5", 0, 0, 0, 1);
      applyRun(1'b0, 5);

      // Fast toggling, 160 ns per level, from a low level
      @(negedge clk);
      base = int'(press_count);
      for (int i = 0; i < 13; i++) begin
         input_sync = ~input_sync;
         #160;
      end
      input_sync = 1'b0;
      applyRun(1'b0, 2);
      checkLiteral("toggle", 0, 0, 0, base);

      // Glitch mid-qualification
      applyRun(1'b0, 4);
      base = int'(press_count);
      applyRun(1'b1, 3);
      applyStimulus(1'b0);
      applyRun(1'b1, 3);
      checkLiteral("glitch_s3", 0, 0, 0, base);
      applyStimulus(1'b1);
      checkLiteral("glitch_s4", 1, 1, 0, (base + 1) % (CMAX + 1));
      applyRun(1'b0, 6);

      // Wrap / saturate with five clean presses
`ifdef PRESS_COUNT_SAT_EN
      expSeq = '{1, 2, 3, 3, 3};
`else
      expSeq = '{1, 2, 3, 0, 1};
`endif
      resetCycle(1'b0);
      @(negedge clk);
      riseSeen = 0;
      for (int p = 0; p < 5; p++) begin
         applyRun(1'b1, 4);
         checkOutput("wrap.count", int'(press_count), expSeq[p]);
         applyRun(1'b1, 1);
         applyRun(1'b0, 5);
      end
      @(negedge clk);
      checkOutput("wrap.rises", riseSeen, 5);

      // Reset on the same edge as the 4th qualifying sample
      resetCycle(1'b0);
      applyRun(1'b0, 2);
      applyRun(1'b1, 3);
      resetCycle(1'b1);
      checkLiteral("rst_accept", 0, 0, 0, 0);
      applyRun(1'b0, 2);
      applyRun(1'b1, 3);
      checkLiteral("rst_accept_s3", 0, 0, 0, 0);
      applyStimulus(1'b1);
      checkLiteral("rst_accept_s4", 1, 1, 0, 1);

      // Randomised runs with occasional resets
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            resetCycle($urandom_range(0, 1) == 1);
         end else begin
            applyRun($urandom_range(0, 1) == 1, $urandom_range(1, 7));
         end
      end

      @(negedge clk);
      checkEn = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
